// File: rtl/seed_collector.sv
// Seed bus receiver: edge-detects the seed strobe, health-tests each seed,
// packs four healthy seeds per 32-bit word and buffers words in a small FIFO.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | not collecting; partial word discarded
// S_COLLECT | capturing seeds on strobe rising edges
// S_FAULT   | health test failed; captures blocked until fault_clear
module seed_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7:0]                    seed_in,
    input  logic                          seed_ready,
    output logic [31:0]                   word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fault,
    output logic                          overflow,
    input  logic                          fault_clear
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FAULT} state_t;

    state_t        state;
    logic          prev_ready;
    logic [1:0]    byte_cnt;
    logic [23:0]   assembly;
    logic [7:0]    last_seed;
    logic [3:0]    rep_cnt;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          capture;
    logic          accept;
    logic [3:0]    rep_next;
    logic          health_fail;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic [31:0]   push_word;

    assign capture     = seed_ready && !prev_ready && (state == S_COLLECT);
    // A capture in a fault_clear or disable cycle is dropped outright.
    assign accept      = capture && enable && !fault_clear;
    assign rep_next    = (seed_in == last_seed) ? rep_cnt + 4'd1 : 4'd1;
    assign health_fail = (seed_in == 8'h00) || (rep_next >= 4'(REP_LIMIT));
    assign push        = accept && !health_fail && (byte_cnt == 2'd3);
    assign push_word   = {seed_in, assembly};

    assign word_valid  = (fifo_level != '0);
    assign word_out    = mem[rd_ptr];
    assign pop         = word_valid && word_ready;
    assign full        = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign push_ok     = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prev_ready <= 1'b0;
            byte_cnt   <= 2'd0;
            assembly   <= '0;
            last_seed  <= 8'h00;
            rep_cnt    <= 4'd0;
            fault      <= 1'b0;
        end else begin
            prev_ready <= seed_ready;
            if (fault_clear)
                fault <= 1'b0;

            if (!enable) begin
                state    <= S_IDLE;
                byte_cnt <= 2'd0;
            end else if (fault_clear || state == S_IDLE) begin
                state     <= S_COLLECT;
                byte_cnt  <= 2'd0;
                last_seed <= 8'h00;
                rep_cnt   <= 4'd0;
            end else if (accept) begin
                if (health_fail) begin
                    fault    <= 1'b1;
                    state    <= S_FAULT;
                    byte_cnt <= 2'd0;
                end else begin
                    case (byte_cnt)
                        2'd0:    assembly[7:0]   <= seed_in;
                        2'd1:    assembly[15:8]  <= seed_in;
                        2'd2:    assembly[23:16] <= seed_in;
                        default: ;
                    endcase
                    byte_cnt  <= byte_cnt + 2'd1;
                    last_seed <= seed_in;
                    rep_cnt   <= rep_next;
                end
            end
        end
    end

    // Full with a same-cycle pop: the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (push_ok && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push_ok)
                fifo_level <= fifo_level - 1'b1;

            if (fault_clear)
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/seed_collector.md
# seed_collector

Receiving end of the random seed generator's seed bus. Samples the 8-bit seed on each rising edge of the seed-ready strobe and runs a health test on it: a repetition count plus an all-zero check for LFSR lockup. Packs four consecutive healthy seeds into a 32-bit word and buffers the words in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4: number of 32-bit words buffered; power of two, 2..16.
- REP_LIMIT, 4: number of consecutive identical seeds that trips the fault; 2..15.
- clk  in  1  system clock; all inputs synchronous to it.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  1 = collect seeds; 0 = idle.
- seed_in  in  8  seed bus from the generator.
- seed_ready  in  1  seed strobe; may stay high for several cycles.
- word_out  out  32  FIFO head word; byte 0 (first seed) is in [7:0].
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts word_out when word_valid is high.
- fifo_level  out  clog2(FIFO_DEPTH)+1  words currently stored.
- fault  out  1  sticky health-test failure.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- fault_clear  in  1  clears fault and overflow, and restarts collection.

## Operation
- Strobe detect: a register holds the previous seed_ready. A capture event occurs in a cycle where seed_ready=1, prev=0, state=COLLECT. A held-high strobe counts once.
- States:
  - IDLE: entered at reset.
    - IDLE -> COLLECT when enable=1.
    - Any state -> IDLE when enable=0; the partial word is discarded.
  - COLLECT: normal capture.
    - COLLECT -> FAULT on a health failure.
  - FAULT: no captures.
    - FAULT -> COLLECT (if enable=1) on fault_clear.
- On a capture, seed_in goes into byte lane byte_cnt of the assembly register and byte_cnt increments (2-bit, wraps 3->0).
- Health test, evaluated on every capture before the byte is stored:
  - seed_in==8'h00 -> fail immediately.
  - seed_in==last_seed -> rep_cnt+1, else rep_cnt=1. rep_cnt reaching REP_LIMIT -> fail.
  - On fail: fault=1, state=FAULT, byte_cnt=0, partial word discarded, failing byte not stored.
- last_seed and rep_cnt reset to 0 and on entering COLLECT.
- Push: the capture with byte_cnt==3 completes a word, which is pushed the same cycle.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped and overflow=1.
  - Full with a simultaneous pop: the push is accepted and the level is unchanged.
- Pop: word_valid && word_ready removes the head. Pop on empty is impossible because valid=0.
- The FIFO survives enable=0 and FAULT; only reset empties it. The consumer can drain the FIFO while in FAULT.
- fault_clear has priority over a same-cycle health failure: the failure is ignored and that capture is dropped.
- fifo_level arithmetic:
  - +1 on push-only, -1 on pop-only, unchanged on both or neither.
  - Never exceeds FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: word_out=0, word_valid=0, fifo_level=0, fault=0, overflow=0, state=IDLE, byte_cnt=0, prev strobe=0.
- Capture latency: seed_in is registered at the clk edge ending the capture cycle T. The 4th capture makes word_valid=1 and fifo_level+1 visible at T+1 when the FIFO was empty.
- fault and overflow assert at T+1 after the offending capture.
- Handshake: the word is transferred at the edge where word_valid && word_ready. word_out shows the next entry, or word_valid drops, at T+1.
- word_out and word_valid must hold stable while word_valid=1 and word_ready=0.
- Minimum strobe spacing: 2 cycles (high one cycle, low one cycle). Back-to-back high without a low gap is one event.
- reset mid-word or mid-handshake: all state is cleared on the next edge and the in-flight word is lost.

## Test plan
- Basic packing:
  - Stimulus: enable=1, word_ready=0; captures 0x01, 0x02, 0x04, 0x08.
  - Response: word_valid=1 with word_out=32'h08040201, fifo_level=1, one cycle after the 4th capture.
- Held strobe:
  - Stimulus: seed_ready high for 5 cycles with seed_in=0x3C, then pulses with 0x11, 0x22, 0x33.
  - Response: word 32'h3322113C; byte_cnt never skips.
- Repetition fault:
  - Stimulus: REP_LIMIT=4; captures 0xA5 x4.
  - Response: fault=1 after the 4th capture, no word pushed, further strobes ignored.
  - Follow-up: fault_clear, then 0x10, 0x20, 0x30, 0x40 -> word 32'h40302010.
- Zero lockup:
  - Stimulus: captures 0x55, 0x00.
  - Response: fault=1, fifo_level stays 0.
- Overflow and simultaneous push/pop:
  - Stimulus: FIFO_DEPTH=4, word_ready=0; 5 words pushed.
  - Response: fifo_level=4, overflow=1, words 1-4 intact in order.
  - Follow-up: with the FIFO full, pop in the same cycle as a 6th word completes -> level stays 4 and the 6th word is appended.
- Reset and disable mid-word:
  - Stimulus: 2 bytes captured, then enable=0, enable=1, 4 new bytes.
  - Response: the word contains only the 4 new bytes.
  - Stimulus: reset asserted with 2 words in the FIFO.
  - Response: word_valid=0 and fifo_level=0 on the next edge.
